bpu_update_queue: RTL and testbench

- Buffers resolved conditional-branch outcomes arriving from the commit stage, up to COMMIT_WIDTH per cycle.
- Drains them one per cycle into the TAGE predictor's update port as a base_predictor_update_info_t.
- Decouples multi-wide commit from the single-ported predictor update path.
- Sits directly upstream of tage_predictor's update input.

---
 rtl/bpu_update_queue_pkg.sv | 20 ++
 rtl/bpu_update_queue_if.sv | 27 ++
 rtl/bpu_update_queue_chk.sv | 16 +
 rtl/bpu_update_queue.sv | 149 ++++++++++++++
 tb/tb_bpu_update_queue.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/bpu_update_queue_pkg.sv
// Shared types and configuration for the branch-predictor update queue that
// sits between multi-wide commit and the TAGE predictor's update port.
package bpu_update_queue_pkg;

    localparam int unsigned BPU_PC_WIDTH           = 32;
    localparam int unsigned BPU_UPDATE_QUEUE_DEPTH = 8;
    localparam int unsigned BPU_COMMIT_WIDTH       = 2;

    typedef struct packed {
        logic                    valid;
        logic [BPU_PC_WIDTH-1:0] pc;
        logic                    taken;
    } base_predictor_update_info_t;

    typedef struct packed {
        logic [BPU_PC_WIDTH-1:0] pc;
        logic                    taken;
    } bpu_update_entry_t;

endpackage

// File: rtl/bpu_update_queue_if.sv
// Commit-side and predictor-side signals of the update queue. The queue is the
// slave; the commit stage / predictor environment is the master.
interface bpu_update_queue_if
    import bpu_update_queue_pkg::*;
#(
    parameter int unsigned DEPTH        = BPU_UPDATE_QUEUE_DEPTH,
    parameter int unsigned COMMIT_WIDTH = BPU_COMMIT_WIDTH
);
    logic [COMMIT_WIDTH-1:0]              commit_valid_i;
    logic [COMMIT_WIDTH*BPU_PC_WIDTH-1:0] commit_pc_i;
    logic [COMMIT_WIDTH-1:0]              commit_taken_i;
    logic                                 queue_ready_o;
    logic                                 update_stall_i;
    base_predictor_update_info_t          update_o;
    logic [$clog2(DEPTH+1)-1:0]           occupancy_o;
    logic [31:0]                          perf_drop_count_o;

    modport master (
        output commit_valid_i, commit_pc_i, commit_taken_i, update_stall_i,
        input  queue_ready_o, update_o, occupancy_o, perf_drop_count_o
    );

    modport slave (
        input  commit_valid_i, commit_pc_i, commit_taken_i, update_stall_i,
        output queue_ready_o, update_o, occupancy_o, perf_drop_count_o
    );
endinterface

// File: rtl/bpu_update_queue_chk.sv
// Property checks on the update queue's occupancy bookkeeping.
module bpu_update_queue_chk #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned OCC_W = 4
) (
    input logic             clk,
    input logic             rst,
    input logic [OCC_W-1:0] occupancy,
    input logic             update_valid
);
    occ_within_depth: assert property (@(posedge clk) disable iff (rst)
        occupancy <= OCC_W'(DEPTH));

    valid_tracks_occ: assert property (@(posedge clk) disable iff (rst)
        update_valid == (occupancy != {OCC_W{1'b0}}));
endmodule

// File: rtl/bpu_update_queue.sv
// Circular FIFO of resolved branch outcomes: accepts up to COMMIT_WIDTH per
// cycle from commit and presents one per cycle to the predictor update port.
module bpu_update_queue
    import bpu_update_queue_pkg::*;
#(
    parameter int unsigned DEPTH        = BPU_UPDATE_QUEUE_DEPTH,
    parameter int unsigned COMMIT_WIDTH = BPU_COMMIT_WIDTH
) (
    input logic               clk,
    input logic               rst,
    bpu_update_queue_if.slave bus
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned OCC_W   = $clog2(DEPTH + 1);
    localparam int unsigned NENQ_W  = $clog2(COMMIT_WIDTH + 1);
    localparam int unsigned ENTRY_W = $bits(bpu_update_entry_t);

    typedef logic [COMMIT_WIDTH*ENTRY_W-1:0] lane_vec_t;

    function automatic logic [NENQ_W-1:0] popcount(input logic [COMMIT_WIDTH-1:0] v);
        logic [NENQ_W-1:0] cnt;
        cnt = {NENQ_W{1'b0}};
        for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
            cnt = cnt + NENQ_W'(v[i]);
        end
        return cnt;
    endfunction

    // Slot 0 receives the lowest valid lane; walking lanes downward and
    // shifting up keeps ascending lane order without a variable index.
    function automatic lane_vec_t compact(
        input logic [COMMIT_WIDTH-1:0]              valid,
        input logic [COMMIT_WIDTH*BPU_PC_WIDTH-1:0] pcs,
        input logic [COMMIT_WIDTH-1:0]              taken
    );
        lane_vec_t         slots;
        bpu_update_entry_t e;
        slots = '0;
        for (int i = int'(COMMIT_WIDTH) - 1; i >= 0; i--) begin
            e.pc    = pcs[i*BPU_PC_WIDTH +: BPU_PC_WIDTH];
            e.taken = taken[i];
            slots   = valid[i] ? ((slots << ENTRY_W) | lane_vec_t'(e)) : slots;
        end
        return slots;
    endfunction

    bpu_update_entry_t mem_q [DEPTH];
    bpu_update_entry_t mem_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [31:0]       drop_q, drop_d;

    logic              ready;
    logic [NENQ_W-1:0] n_enq;
    logic              enq_fire;
    logic              deq_fire;
    lane_vec_t         slots;
    logic [32:0]       drop_sum;

    // Handshake decisions; readiness deliberately ignores a same-cycle dequeue.
    always_comb begin
        ready    = (OCC_W'(DEPTH) - occ_q) >= OCC_W'(COMMIT_WIDTH);
        n_enq    = popcount(bus.commit_valid_i);
        enq_fire = ready && (n_enq != {NENQ_W{1'b0}});
        deq_fire = (occ_q != {OCC_W{1'b0}}) && !bus.update_stall_i;
        slots    = compact(bus.commit_valid_i, bus.commit_pc_i, bus.commit_taken_i);
        drop_sum = {1'b0, drop_q} + 33'(n_enq);
    end

    // Next-state for pointers, occupancy, storage and the drop counter.
    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < int'(COMMIT_WIDTH); j++) begin
            mem_d[tail_q + PTR_W'(j)] = (enq_fire && (NENQ_W'(j) < n_enq))
                ? bpu_update_entry_t'(slots[j*ENTRY_W +: ENTRY_W])
                : mem_q[tail_q + PTR_W'(j)];
        end

        if (enq_fire) begin
            tail_d = tail_q + PTR_W'(n_enq);
        end else begin
            tail_d = tail_q;
        end

        if (deq_fire) begin
            head_d = head_q + PTR_W'(1'b1);
        end else begin
            head_d = head_q;
        end

        occ_d = occ_q
              + (enq_fire ? OCC_W'(n_enq) : {OCC_W{1'b0}})
              - (deq_fire ? OCC_W'(1'b1)  : {OCC_W{1'b0}});

        if (!ready) begin
            drop_d = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
        end else begin
            drop_d = drop_q;
        end
    end

    // State registers; reset discards every entry immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= {PTR_W{1'b0}};
            tail_q <= {PTR_W{1'b0}};
            occ_q  <= {OCC_W{1'b0}};
            drop_q <= 32'h0000_0000;
            for (int k = 0; k < int'(DEPTH); k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            drop_q <= drop_d;
            mem_q  <= mem_d;
        end
    end

    // Head entry is presented directly; an empty queue shows zeros, not stale data.
    always_comb begin
        if (occ_q != {OCC_W{1'b0}}) begin
            bus.update_o.valid = 1'b1;
            bus.update_o.pc    = mem_q[head_q].pc;
            bus.update_o.taken = mem_q[head_q].taken;
        end else begin
            bus.update_o.valid = 1'b0;
            bus.update_o.pc    = {BPU_PC_WIDTH{1'b0}};
            bus.update_o.taken = 1'b0;
        end
    end

    assign bus.queue_ready_o     = ready;
    assign bus.occupancy_o       = occ_q;
    assign bus.perf_drop_count_o = drop_q;

    bpu_update_queue_chk #(
        .DEPTH (DEPTH),
        .OCC_W (OCC_W)
    ) u_chk (
        .clk          (clk),
        .rst          (rst),
        .occupancy    (occ_q),
        .update_valid (bus.update_o.valid)
    );

endmodule

// File: tb/tb_bpu_update_queue.sv
// Directed bench for bpu_update_queue: a queue-based reference model checked
// every cycle, plus hand-computed expectations at key points.
module tb_bpu_update_queue;
    import bpu_update_queue_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bpu_update_queue_if #(.DEPTH(8), .COMMIT_WIDTH(2)) bus();

    bpu_update_queue #(.DEPTH(8), .COMMIT_WIDTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    bit done   = 1'b0;
    bit cap_en = 1'b0;

    bpu_update_entry_t mq[$];
    longint unsigned   mdrop = 0;
    logic [31:0]       obs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO with capacity/drop rules applied per edge.
    task automatic model_step();
        bpu_update_entry_t e;
        int  n;
        bit  room;
        bit  deq;
        if (rst) begin
            mq.delete();
            mdrop = 0;
        end else begin
            n    = 0;
            for (int i = 0; i < 2; i++) n += int'(bus.commit_valid_i[i]);
            room = (8 - mq.size()) >= 2;
            deq  = (mq.size() != 0) && !bus.update_stall_i;
            if (deq) void'(mq.pop_front());
            if (room) begin
                for (int i = 0; i < 2; i++) begin
                    if (bus.commit_valid_i[i]) begin
                        e.pc    = bus.commit_pc_i[32*i +: 32];
                        e.taken = bus.commit_taken_i[i];
                        mq.push_back(e);
                    end
                end
            end else begin
                mdrop = mdrop + longint'(n);
                if (mdrop > 64'h0000_0000_FFFF_FFFF) mdrop = 64'h0000_0000_FFFF_FFFF;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        logic [31:0] epc;
        logic        et;
        @(negedge clk);
        if (!done) begin
            epc = (mq.size() != 0) ? mq[0].pc : 32'h0;
            et  = (mq.size() != 0) ? mq[0].taken : 1'b0;
            chk("m_valid", 64'(bus.update_o.valid), 64'(mq.size() != 0));
            chk("m_pc",    64'(bus.update_o.pc),    64'(epc));
            chk("m_taken", 64'(bus.update_o.taken), 64'(et));
            chk("m_occ",   64'(bus.occupancy_o),    64'(mq.size()));
            chk("m_ready", 64'(bus.queue_ready_o),  64'((8 - mq.size()) >= 2));
            chk("m_drop",  64'(bus.perf_drop_count_o), 64'(mdrop));
        end
    end

    initial forever begin
        @(posedge clk);
        if (cap_en && !rst && bus.update_o.valid && !bus.update_stall_i)
            obs.push_back(bus.update_o.pc);
    end

    task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic t0,
                         input logic [31:0] p1, input logic t1, input logic st);
        bus.commit_valid_i = v;
        bus.commit_pc_i    = {p1, p0};
        bus.commit_taken_i = {t1, t0};
        bus.update_stall_i = st;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic st);
        drive(2'b00, 32'h0, 1'b0, 32'h0, 1'b0, st);
    endtask

    task automatic hv(input string name, input logic v, input logic [31:0] pc,
                      input logic t, input int occ);
        chk({name, "_valid"}, 64'(bus.update_o.valid), 64'(v));
        chk({name, "_pc"},    64'(bus.update_o.pc),    64'(pc));
        chk({name, "_taken"}, 64'(bus.update_o.taken), 64'(t));
        chk({name, "_occ"},   64'(bus.occupancy_o),    64'(occ));
    endtask

    initial begin
        logic [19:0] stall_pat;
        int          guard;
        stall_pat = 20'b0110_1001_0010_1101_0100;
        bus.commit_valid_i = 2'b00;
        bus.commit_pc_i    = 64'h0;
        bus.commit_taken_i = 2'b00;
        bus.update_stall_i = 1'b0;

        #1 rst = 1'b1;
        #1;
        hv("rst", 1'b0, 32'h0, 1'b0, 0);
        chk("rst_ready", 64'(bus.queue_ready_o), 64'd1);
        chk("rst_drop",  64'(bus.perf_drop_count_o), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        idle(1'b0);
        hv("idle", 1'b0, 32'h0, 1'b0, 0);
        chk("idle_ready", 64'(bus.queue_ready_o), 64'd1);

        drive(2'b01, 32'h1c00_0100, 1'b1, 32'h0, 1'b0, 1'b0);
        hv("single", 1'b1, 32'h1c00_0100, 1'b1, 1);
        idle(1'b0);
        hv("single_drain", 1'b0, 32'h0, 1'b0, 0);

        drive(2'b11, 32'h100, 1'b1, 32'h104, 1'b0, 1'b1);
        hv("pair", 1'b1, 32'h100, 1'b1, 2);
        idle(1'b1);
        hv("pair_hold", 1'b1, 32'h100, 1'b1, 2);
        idle(1'b0);
        hv("pair_second", 1'b1, 32'h104, 1'b0, 1);
        idle(1'b0);
        hv("pair_empty", 1'b0, 32'h0, 1'b0, 0);

        drive(2'b01, 32'h300, 1'b0, 32'h0, 1'b0, 1'b1);
        drive(2'b10, 32'h0, 1'b0, 32'h204, 1'b1, 1'b1);
        hv("lane1_behind", 1'b1, 32'h300, 1'b0, 2);
        idle(1'b0);
        hv("lane1_tail", 1'b1, 32'h204, 1'b1, 1);
        idle(1'b0);
        drive(2'b10, 32'h0, 1'b0, 32'h200, 1'b1, 1'b0);
        hv("lane1_only", 1'b1, 32'h200, 1'b1, 1);
        idle(1'b0);

        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 32'h400 + 32'(8*k), 1'b1, 32'h404 + 32'(8*k), 1'b0, 1'b1);
            chk("fill_occ",   64'(bus.occupancy_o),   64'(2*(k+1)));
            chk("fill_ready", 64'(bus.queue_ready_o), 64'(k < 3));
        end
        drive(2'b11, 32'h500, 1'b1, 32'h504, 1'b1, 1'b1);
        hv("drop1", 1'b1, 32'h400, 1'b1, 8);
        chk("drop1_cnt", 64'(bus.perf_drop_count_o), 64'd2);
        drive(2'b11, 32'h508, 1'b1, 32'h50c, 1'b1, 1'b1);
        chk("drop2_cnt", 64'(bus.perf_drop_count_o), 64'd4);
        drive(2'b11, 32'h600, 1'b1, 32'h604, 1'b1, 1'b0);
        hv("full_deq", 1'b1, 32'h404, 1'b0, 7);
        chk("full_deq_drop",  64'(bus.perf_drop_count_o), 64'd6);
        chk("occ7_ready", 64'(bus.queue_ready_o), 64'd0);
        drive(2'b01, 32'h700, 1'b1, 32'h0, 1'b0, 1'b1);
        chk("occ7_drop", 64'(bus.perf_drop_count_o), 64'd7);
        repeat (7) idle(1'b0);
        hv("fill_drained", 1'b0, 32'h0, 1'b0, 0);

        obs.delete();
        cap_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            guard = 0;
            while (!bus.queue_ready_o && guard < 20) begin
                idle(1'b0);
                guard++;
            end
            chk("wrap_wait", 64'(guard < 20), 64'd1);
            if (i % 2 == 0)
                drive(2'b01, 32'h1000 + 32'(4*i), 1'(i % 3), 32'h0, 1'b0, stall_pat[i]);
            else
                drive(2'b10, 32'h0, 1'b0, 32'h1000 + 32'(4*i), 1'(i % 3), stall_pat[i]);
        end
        repeat (10) idle(1'b0);
        cap_en = 1'b0;
        chk("wrap_count", 64'(obs.size()), 64'd20);
        for (int k = 0; k < 20; k++) begin
            if (k < obs.size()) chk("wrap_order", 64'(obs[k]), 64'(32'h1000 + 32'(4*k)));
            else                chk("wrap_order", 64'hDEAD, 64'(32'h1000 + 32'(4*k)));
        end

        drive(2'b11, 32'h800, 1'b0, 32'h804, 1'b1, 1'b1);
        drive(2'b11, 32'h808, 1'b0, 32'h80c, 1'b1, 1'b1);
        drive(2'b01, 32'h810, 1'b1, 32'h0, 1'b0, 1'b1);
        hv("pre_rst", 1'b1, 32'h800, 1'b0, 5);
        #2 rst = 1'b1;
        #1;
        hv("mid_rst", 1'b0, 32'h0, 1'b0, 0);
        chk("mid_rst_ready", 64'(bus.queue_ready_o), 64'd1);
        chk("mid_rst_drop",  64'(bus.perf_drop_count_o), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(2'b01, 32'hABC0, 1'b1, 32'h0, 1'b0, 1'b0);
        hv("post_rst", 1'b1, 32'hABC0, 1'b1, 1);
        idle(1'b0);
        hv("post_rst_empty", 1'b0, 32'h0, 1'b0, 0);

        done = 1'b1;
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
